serial_mag_comparator: RTL

SERIAL_MAG_COMPARATOR -- requirements
Module: serial_mag_comparator

---
 rtl/cmp_pkg.sv | 10 +
 rtl/comp2_slice.sv | 18 +
 rtl/serial_mag_comparator.sv | 115 +++++++++++
 3 files changed

// File: rtl/cmp_pkg.sv
// Shared definitions for the serial magnitude comparator: FSM encodings and slice width.
package cmp_pkg;

    localparam int unsigned SLICE_W = 2;

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] COMPARE = 2'd1;
    localparam logic [1:0] DONE    = 2'd2;

endpackage

// File: rtl/comp2_slice.sv
// Combinational 2-bit unsigned compare; exactly one of gt/eq/lt is high.
module comp2_slice
    import cmp_pkg::*;
(
    input  logic [SLICE_W-1:0] x,
    input  logic [SLICE_W-1:0] y,
    output logic               gt,
    output logic               eq,
    output logic               lt
);

    always_comb begin
        gt = (x > y);
        eq = (x == y);
        lt = (x < y);
    end

endmodule

// File: rtl/serial_mag_comparator.sv
// Serial unsigned magnitude comparator: one 2-bit slice per clock, MSB first,
// terminating early on the first unequal slice.
module serial_mag_comparator
    import cmp_pkg::*;
#(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic             gt,
    output logic             eq,
    output logic             lt
);

    localparam int unsigned SLICES = WIDTH / SLICE_W;
    localparam int unsigned CNT_W  = (SLICES > 1) ? $clog2(SLICES) : 1;
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(SLICES - 1);

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             gt_q, gt_d, eq_q, eq_d, lt_q, lt_d;
    logic             s_gt, s_eq, s_lt;

    comp2_slice u_slice (
        .x  (a_q[WIDTH-1 -: SLICE_W]),
        .y  (b_q[WIDTH-1 -: SLICE_W]),
        .gt (s_gt),
        .eq (s_eq),
        .lt (s_lt)
    );

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        cnt_d   = cnt_q;
        gt_d    = gt_q;
        eq_d    = eq_q;
        lt_d    = lt_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    a_d     = a;
                    b_d     = b;
                    cnt_d   = '0;
                    state_d = COMPARE;
                end
            end
            COMPARE: begin
                if (!s_eq) begin
                    gt_d    = s_gt;
                    eq_d    = 1'b0;
                    lt_d    = s_lt;
                    state_d = DONE;
                end else if (cnt_q == LAST_IDX) begin
                    gt_d    = 1'b0;
                    eq_d    = 1'b1;
                    lt_d    = 1'b0;
                    state_d = DONE;
                end else begin
                    a_d   = a_q << SLICE_W;
                    b_d   = b_q << SLICE_W;
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            DONE: begin
                // Back-to-back: a start seen during the done pulse is accepted at once.
                if (start) begin
                    a_d     = a;
                    b_d     = b;
                    cnt_d   = '0;
                    state_d = COMPARE;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            cnt_q   <= '0;
            gt_q    <= 1'b0;
            eq_q    <= 1'b0;
            lt_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            cnt_q   <= cnt_d;
            gt_q    <= gt_d;
            eq_q    <= eq_d;
            lt_q    <= lt_d;
        end
    end

    always_comb begin
        busy = (state_q == COMPARE);
        done = (state_q == DONE);
        gt   = gt_q;
        eq   = eq_q;
        lt   = lt_q;
    end

endmodule
